// File: rtl/ddr2_cmd_issue.sv
// ddr2_cmd_issue: registered DDR2 command issue stage with per-command spacing timer.
// All ctrl_ddr2_* outputs and cmd_ready come straight from flops.
module ddr2_cmd_issue #(
    parameter int ROW_ADDRESS  = 14,
    parameter int BANK_ADDRESS = 3,
    parameter int CS_WIDTH     = 1,
    parameter int CKE_WIDTH    = 1,
    parameter int ODT_WIDTH    = 1,
    parameter int TRCD         = 4,
    parameter int TRP          = 4,
    parameter int TRFC         = 26,
    parameter int TMRD         = 2,
    parameter int TCCD         = 2
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [ROW_ADDRESS-1:0]  cmd_addr,
    input  logic [BANK_ADDRESS-1:0] cmd_ba,
    input  logic [CS_WIDTH-1:0]     cmd_cs,
    input  logic [CKE_WIDTH-1:0]    cke_en,
    input  logic [ODT_WIDTH-1:0]    odt_en,
    output logic                    ctrl_ddr2_ras_l,
    output logic                    ctrl_ddr2_cas_l,
    output logic                    ctrl_ddr2_we_l,
    output logic [CS_WIDTH-1:0]     ctrl_ddr2_cs_l,
    output logic [ROW_ADDRESS-1:0]  ctrl_ddr2_address,
    output logic [BANK_ADDRESS-1:0] ctrl_ddr2_ba,
    output logic [CKE_WIDTH-1:0]    ctrl_ddr2_cke,
    output logic [ODT_WIDTH-1:0]    ctrl_ddr2_odt
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       issue_d;
    logic [2:0] enc_d;
    logic [7:0] dly_d;

    // NOP (0) and reserved (7) are accepted but never reach the bus.
    always_comb begin
        issue_d = cmd_valid & cmd_ready & (cmd_op != 3'd0) & (cmd_op != 3'd7);
        enc_d   = cmd_op == 3'd1 ? 3'b011 :
                  cmd_op == 3'd2 ? 3'b101 :
                  cmd_op == 3'd3 ? 3'b100 :
                  cmd_op == 3'd4 ? 3'b010 :
                  cmd_op == 3'd5 ? 3'b001 : 3'b000;
        dly_d   = cmd_op == 3'd1 ? 8'(TRCD) :
                  cmd_op == 3'd4 ? 8'(TRP)  :
                  cmd_op == 3'd5 ? 8'(TRFC) :
                  cmd_op == 3'd6 ? 8'(TMRD) : 8'(TCCD);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            cmd_ready         <= 1'b0;
            ctrl_ddr2_ras_l   <= 1'b1;
            ctrl_ddr2_cas_l   <= 1'b1;
            ctrl_ddr2_we_l    <= 1'b1;
            ctrl_ddr2_cs_l    <= '1;
            ctrl_ddr2_address <= '0;
            ctrl_ddr2_ba      <= '0;
            ctrl_ddr2_cke     <= '0;
            ctrl_ddr2_odt     <= '0;
        end else begin
            {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l} <= issue_d ? enc_d : 3'b111;
            ctrl_ddr2_cs_l <= issue_d ? ~cmd_cs : '1;
            ctrl_ddr2_cke  <= cke_en;
            ctrl_ddr2_odt  <= odt_en;
            if (issue_d) begin
                ctrl_ddr2_address <= cmd_addr;
                ctrl_ddr2_ba      <= cmd_ba;
            end
            // Ready rises when the counter hits 1, so the next command lands D cycles after this one.
            case (state_q)
                IDLE: begin
                    state_q   <= issue_d ? WAIT : IDLE;
                    cnt_q     <= issue_d ? dly_d - 8'd1 : 8'd0;
                    cmd_ready <= ~issue_d;
                end
                default: begin
                    state_q   <= cnt_q == 8'd1 ? IDLE : WAIT;
                    cnt_q     <= cnt_q - 8'd1;
                    cmd_ready <= cnt_q == 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr2_cmd_issue.sv
// tb_ddr2_cmd_issue: directed scenario tests for ddr2_cmd_issue with hand-computed expectations.
module tb_ddr2_cmd_issue;
    localparam logic [2:0] OP_NOP = 3'd0, OP_ACT = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4, OP_REF = 3'd5, OP_MRS = 3'd6, OP_RSV = 3'd7;
    localparam logic [2:0] ENC [8] = '{3'b111, 3'b011, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000, 3'b111};
    localparam int         DLY [8] = '{0, 4, 2, 2, 4, 26, 2, 0};
    localparam logic [3:0] DESEL = 4'b1111;

    logic        clk0 = 1'b0;
    logic        rst0, cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [13:0] cmd_addr, ctrl_ddr2_address;
    logic [2:0]  cmd_ba, ctrl_ddr2_ba;
    logic        cmd_cs, cke_en, odt_en;
    logic        ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l;
    logic        ctrl_ddr2_cs_l, ctrl_ddr2_cke, ctrl_ddr2_odt;
    logic [3:0]  bus;
    int          n_cmp = 0, n_err = 0;

    ddr2_cmd_issue dut (
        .clk0(clk0), .rst0(rst0), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_ba(cmd_ba), .cmd_cs(cmd_cs),
        .cke_en(cke_en), .odt_en(odt_en),
        .ctrl_ddr2_ras_l(ctrl_ddr2_ras_l), .ctrl_ddr2_cas_l(ctrl_ddr2_cas_l),
        .ctrl_ddr2_we_l(ctrl_ddr2_we_l), .ctrl_ddr2_cs_l(ctrl_ddr2_cs_l),
        .ctrl_ddr2_address(ctrl_ddr2_address), .ctrl_ddr2_ba(ctrl_ddr2_ba),
        .ctrl_ddr2_cke(ctrl_ddr2_cke), .ctrl_ddr2_odt(ctrl_ddr2_odt)
    );

    always #5 clk0 = ~clk0;
    assign bus = {ctrl_ddr2_cs_l, ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l};

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && cmd_ready !== 1'b1; i++) tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle-timeout: cmd_ready=%b want 1", name, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; cke_en = 1'b1; odt_en = 1'b0; cmd_cs = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_ACT; cmd_addr = 14'h3FFF; cmd_ba = 3'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({cmd_ready, bus, ctrl_ddr2_cke, ctrl_ddr2_odt, ctrl_ddr2_address, ctrl_ddr2_ba} !==
                {1'b0, DESEL, 1'b0, 1'b0, 14'h0, 3'h0}) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: rdy=%b bus=%b cke=%b odt=%b addr=%h ba=%h want 0 1111 0 0 0000 0",
                         k, cmd_ready, bus, ctrl_ddr2_cke, ctrl_ddr2_odt, ctrl_ddr2_address, ctrl_ddr2_ba);
            end
        end
        rst0 = 1'b0; cmd_valid = 1'b0; odt_en = 1'b1;
        tick();
        n_cmp++;
        if ({cmd_ready, ctrl_ddr2_cke, ctrl_ddr2_odt, bus} !== {3'b111, DESEL}) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b cke=%b odt=%b bus=%b want 1 1 1 1111",
                     cmd_ready, ctrl_ddr2_cke, ctrl_ddr2_odt, bus);
        end
    endtask

    task automatic test_act_rd();
        cmd_valid = 1'b1; cmd_op = OP_ACT; cmd_addr = 14'h1A5; cmd_ba = 3'd2;
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready} !== {4'b0011, 14'h1A5, 3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL act_issue: bus=%b addr=%h ba=%h rdy=%b want 0011 01a5 2 0",
                     bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready);
        end
        cmd_op = OP_RD; cmd_addr = 14'h010;
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_cmp++;
            if ({bus, ctrl_ddr2_address, cmd_ready} !== {DESEL, 14'h1A5, k == 4}) begin
                n_err++;
                $display("FAIL act_wait[%0d]: bus=%b addr=%h rdy=%b want 1111 01a5 %b",
                         k, bus, ctrl_ddr2_address, cmd_ready, k == 4);
            end
        end
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready} !== {4'b0101, 14'h010, 3'd2, 1'b0}) begin
            n_err++;
            $display("FAIL rd_issue: bus=%b addr=%h ba=%h rdy=%b want 0101 0010 2 0",
                     bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready);
        end
        cmd_valid = 1'b0;
        tick();
        n_cmp++;
        if ({bus, cmd_ready} !== {DESEL, 1'b1}) begin
            n_err++;
            $display("FAIL rd_tccd: bus=%b rdy=%b want 1111 1", bus, cmd_ready);
        end
    endtask

    task automatic test_ref_act();
        cmd_valid = 1'b1; cmd_op = OP_REF; cmd_addr = 14'h3FF; cmd_ba = 3'd5;
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba} !== {4'b0001, 14'h3FF, 3'd5}) begin
            n_err++;
            $display("FAIL ref_issue: bus=%b addr=%h ba=%h want 0001 03ff 5", bus, ctrl_ddr2_address, ctrl_ddr2_ba);
        end
        cmd_op = OP_ACT; cmd_addr = 14'h0AB; cmd_ba = 3'd1;
        for (int k = 2; k <= 26; k++) begin
            tick();
            n_cmp++;
            if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready} !== {DESEL, 14'h3FF, 3'd5, k == 26}) begin
                n_err++;
                $display("FAIL ref_wait[%0d]: bus=%b addr=%h ba=%h rdy=%b want 1111 03ff 5 %b",
                         k, bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready, k == 26);
            end
        end
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba} !== {4'b0011, 14'h0AB, 3'd1}) begin
            n_err++;
            $display("FAIL ref_act_trfc: bus=%b addr=%h ba=%h want 0011 00ab 1", bus, ctrl_ddr2_address, ctrl_ddr2_ba);
        end
        cmd_valid = 1'b0;
        wait_idle("ref_act");
    endtask

    task automatic test_back_to_back_nops();
        logic [2:0] nops [3] = '{OP_NOP, OP_RSV, OP_NOP};
        cmd_valid = 1'b1; cmd_addr = 14'h055; cmd_ba = 3'd6; odt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_op = nops[k];
            tick();
            n_cmp++;
            if ({bus, cmd_ready, ctrl_ddr2_address, ctrl_ddr2_ba} !== {DESEL, 1'b1, 14'h0AB, 3'd1}) begin
                n_err++;
                $display("FAIL nop[%0d]: bus=%b rdy=%b addr=%h ba=%h want 1111 1 00ab 1",
                         k, bus, cmd_ready, ctrl_ddr2_address, ctrl_ddr2_ba);
            end
        end
        n_cmp++;
        if (ctrl_ddr2_odt !== 1'b0) begin
            n_err++;
            $display("FAIL odt_follow: odt=%b want 0", ctrl_ddr2_odt);
        end
        cmd_op = OP_WR; cmd_addr = 14'h020; cmd_ba = 3'd3;
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready} !== {4'b0100, 14'h020, 3'd3, 1'b0}) begin
            n_err++;
            $display("FAIL wr_after_nops: bus=%b addr=%h ba=%h rdy=%b want 0100 0020 3 0",
                     bus, ctrl_ddr2_address, ctrl_ddr2_ba, cmd_ready);
        end
        cmd_valid = 1'b0;
        wait_idle("wr");
    endtask

    task automatic test_reset_mid_wait();
        cmd_valid = 1'b1; cmd_op = OP_PRE; cmd_addr = 14'h400; cmd_ba = 3'd4;
        tick();
        n_cmp++;
        if (bus !== 4'b0010) begin
            n_err++;
            $display("FAIL pre_issue: bus=%b want 0010", bus);
        end
        cmd_valid = 1'b0; rst0 = 1'b1;
        tick();
        n_cmp++;
        if ({cmd_ready, bus, ctrl_ddr2_address, ctrl_ddr2_ba, ctrl_ddr2_cke} !== {1'b0, DESEL, 14'h0, 3'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_wait: rdy=%b bus=%b addr=%h ba=%h cke=%b want 0 1111 0000 0 0",
                     cmd_ready, bus, ctrl_ddr2_address, ctrl_ddr2_ba, ctrl_ddr2_cke);
        end
        rst0 = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_ready: rdy=%b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = OP_ACT; cmd_addr = 14'h007; cmd_ba = 3'd0;
        tick();
        n_cmp++;
        if ({bus, ctrl_ddr2_address} !== {4'b0011, 14'h007}) begin
            n_err++;
            $display("FAIL reset_no_residual: bus=%b addr=%h want 0011 0007", bus, ctrl_ddr2_address);
        end
        cmd_valid = 1'b0;
        wait_idle("reset_mid");
    endtask

    task automatic test_held_valid();
        logic [2:0] ops [8] = '{OP_RD, OP_NOP, OP_ACT, OP_RSV, OP_WR, OP_PRE, OP_MRS, OP_REF};
        int         rem = 0, hs = 0, seen = 0;
        logic       exp_iss;
        logic [2:0] op;
        cmd_valid = 1'b1; cmd_ba = 3'd2;
        for (int i = 0; i < 60; i++) begin
            op = ops[i % 8];
            cmd_op = op; cmd_addr = 14'(i + 100);
            exp_iss = rem == 0 && op != OP_NOP && op != OP_RSV;
            n_cmp++;
            if (cmd_ready !== (rem == 0)) begin
                n_err++;
                $display("FAIL held_ready[%0d]: rdy=%b want %b", i, cmd_ready, rem == 0);
            end
            tick();
            if (exp_iss) begin
                hs++;
                rem = DLY[op] - 1;
            end else if (rem > 0) rem--;
            if (bus !== DESEL) seen++;
            n_cmp++;
            if (exp_iss ? {bus, ctrl_ddr2_address} !== {1'b0, ENC[op], 14'(i + 100)} : bus !== DESEL) begin
                n_err++;
                $display("FAIL held_bus[%0d]: bus=%b addr=%h issue=%b op=%0d", i, bus, ctrl_ddr2_address, exp_iss, op);
            end
        end
        n_cmp++;
        if (seen != hs) begin
            n_err++;
            $display("FAIL held_count: bus commands=%0d want %0d", seen, hs);
        end
        cmd_valid = 1'b0;
        wait_idle("held");
    endtask

    initial begin
        rst0 = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = '0; cmd_ba = '0;
        cmd_cs = 1'b1; cke_en = 1'b0; odt_en = 1'b0;
        test_reset();
        test_act_rd();
        test_ref_act();
        test_back_to_back_nops();
        test_reset_mid_wait();
        test_held_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
